ad9253_lvds_tx_emulator: RTL and testbench

//  Transmit-side emulator of the AD9253 2-lane DDR LVDS output (4 channels, 14-bit).

---
 rtl/ad9253_pkg.sv | 15 +
 rtl/ad9253_lane_serializer.sv | 20 ++
 rtl/ad9253_lvds_tx_emulator.sv | 98 +++++++++
 tb/tb_ad9253_lvds_tx_emulator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ad9253_pkg.sv
// ad9253_pkg: shared widths, FSM states and lane-word split for the AD9253 2-lane LVDS link
package ad9253_pkg;
  localparam int SAMPLE_W = 14;
  localparam int LANE_BITS = 8;
  localparam int HALF_LEN = 16;
  localparam int N_CH = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_RUN} state_t;
  typedef struct packed {
    logic [LANE_BITS-1:0] h;
    logic [LANE_BITS-1:0] l;
  } lane_word_t;
  function automatic lane_word_t lane_split(input logic [SAMPLE_W-1:0] s);
    return '{h: s[13:6], l: {s[5:0], 2'b00}};
  endfunction
endpackage

// File: rtl/ad9253_lane_serializer.sv
// ad9253_lane_serializer: one channel's H/L lane pair, MSB-first 8-bit shift registers
module ad9253_lane_serializer
  import ad9253_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                h,
  output logic                l
);
  lane_word_t sr;
  always_ff @(posedge clk)
    if (rst) sr <= '0;
    else if (load) sr <= lane_split(sample);
    else if (shift) sr <= {sr.h[LANE_BITS-2:0], 1'b0, sr.l[LANE_BITS-2:0], 1'b0};
  assign h = sr.h[LANE_BITS-1];
  assign l = sr.l[LANE_BITS-1];
endmodule

// File: rtl/ad9253_lvds_tx_emulator.sv
// ad9253_lvds_tx_emulator: serializes 4-channel samples onto AD9253-style DDR lanes with DCO/FCO
module ad9253_lvds_tx_emulator
  import ad9253_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] IDLE_WORD = 14'h2000,
  parameter int PREAMBLE_FRAMES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                S_VLD,
  output logic                S_RDY,
  input  logic [SAMPLE_W-1:0] S_CH0,
  input  logic [SAMPLE_W-1:0] S_CH1,
  input  logic [SAMPLE_W-1:0] S_CH2,
  input  logic [SAMPLE_W-1:0] S_CH3,
  output logic                DCO,
  output logic                FCO,
  output logic                Data_A_H,
  output logic                Data_A_L,
  output logic                Data_B_H,
  output logic                Data_B_L,
  output logic                Data_C_H,
  output logic                Data_C_L,
  output logic                Data_D_H,
  output logic                Data_D_L,
  output logic                BUSY,
  output logic                UNDERRUN
);
  localparam logic [4:0] PRE_LAST = 5'(2 * PREAMBLE_FRAMES - 1);
  localparam logic [3:0] PH_LAST = 4'(HALF_LEN - 1);
  state_t state, state_n;
  logic [3:0] ph, ph_n;
  logic half, half_n;
  logic [4:0] pre_cnt;
  logic full, rdy_ok, dco_q, fco_q, und_q;
  logic busy, end_half, start, stop, last_pre, load, ser_load, shift, accept;
  logic [SAMPLE_W-1:0] s_in [N_CH];
  logic [SAMPLE_W-1:0] hold [N_CH];
  logic [SAMPLE_W-1:0] word [N_CH];
  logic [N_CH-1:0] lane_h, lane_l;
  assign s_in = '{S_CH0, S_CH1, S_CH2, S_CH3};
  assign busy = state != ST_IDLE;
  assign end_half = busy && ph == PH_LAST;
  assign start = state == ST_IDLE && EN;
  // EN only matters at the close of the FCO-low half, so frames are never truncated
  assign stop = state == ST_RUN && end_half && !half && !EN;
  assign last_pre = state == ST_PREAMBLE && end_half && pre_cnt == PRE_LAST;
  assign load = (state == ST_RUN && end_half && !stop) || last_pre;
  assign ser_load = start || end_half;
  assign shift = busy && ph[0] && !end_half;
  assign accept = S_VLD && S_RDY;
  assign ph_n = busy ? ph + 4'd1 : 4'd0;
  assign half_n = start || (end_half ? !half && !stop : half);
  always_comb begin
    state_n = state;
    state_n = start ? ST_PREAMBLE : last_pre ? ST_RUN : stop ? ST_IDLE : state;
    for (int c = 0; c < N_CH; c++)
      word[c] = stop ? '0 : (load && full) ? hold[c] : IDLE_WORD;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state <= ST_IDLE;
      ph <= '0;
      half <= 1'b0;
      pre_cnt <= '0;
      full <= 1'b0;
      rdy_ok <= 1'b0;
      dco_q <= 1'b0;
      fco_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      half <= half_n;
      pre_cnt <= start ? '0 : (state == ST_PREAMBLE && end_half) ? pre_cnt + 5'd1 : pre_cnt;
      full <= accept || (full && !load);
      rdy_ok <= 1'b1;
      dco_q <= ph_n[1] ^ ph_n[0];
      fco_q <= half_n;
      und_q <= load && !full;
    end
  always_ff @(posedge CLK)
    if (accept) hold <= s_in;
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    ad9253_lane_serializer u_ser (
      .clk(CLK), .rst(RST), .load(ser_load), .shift(shift),
      .sample(word[i]), .h(lane_h[i]), .l(lane_l[i])
    );
  end
  assign S_RDY = rdy_ok && (!full || load);
  assign DCO = dco_q;
  assign FCO = fco_q;
  assign BUSY = busy;
  assign UNDERRUN = und_q;
  assign {Data_D_H, Data_C_H, Data_B_H, Data_A_H} = lane_h;
  assign {Data_D_L, Data_C_L, Data_B_L, Data_A_L} = lane_l;
endmodule

// File: tb/tb_ad9253_lvds_tx_emulator.sv
// tb_ad9253_lvds_tx_emulator: directed checks of framing, handshake, preamble, stop and reset
module tb_ad9253_lvds_tx_emulator;
  logic CLK = 1'b0, RST = 1'b1, EN = 1'b0, S_VLD = 1'b0;
  logic [13:0] S_CH0 = '0, S_CH1 = '0, S_CH2 = '0, S_CH3 = '0;
  logic S_RDY, DCO, FCO, BUSY, UNDERRUN;
  logic Data_A_H, Data_A_L, Data_B_H, Data_B_L, Data_C_H, Data_C_L, Data_D_H, Data_D_L;
  int errors = 0, checks = 0;
  logic [55:0] q[$];
  bit xfer = 1'b0;

  ad9253_lvds_tx_emulator dut (
    .CLK(CLK), .RST(RST), .EN(EN), .S_VLD(S_VLD), .S_RDY(S_RDY),
    .S_CH0(S_CH0), .S_CH1(S_CH1), .S_CH2(S_CH2), .S_CH3(S_CH3),
    .DCO(DCO), .FCO(FCO),
    .Data_A_H(Data_A_H), .Data_A_L(Data_A_L), .Data_B_H(Data_B_H), .Data_B_L(Data_B_L),
    .Data_C_H(Data_C_H), .Data_C_L(Data_C_L), .Data_D_H(Data_D_H), .Data_D_L(Data_D_L),
    .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  wire [3:0] lh = {Data_D_H, Data_C_H, Data_B_H, Data_A_H};
  wire [3:0] ll = {Data_D_L, Data_C_L, Data_B_L, Data_A_L};
  wire [11:0] outs = {lh, ll, DCO, FCO, BUSY, UNDERRUN};

  // sample source: presents queue head, pops after each handshake edge
  always @(negedge CLK) begin
    if (xfer && q.size() > 0) void'(q.pop_front());
    S_VLD = q.size() > 0;
    if (S_VLD) {S_CH3, S_CH2, S_CH1, S_CH0} = q[0];
    xfer = S_VLD && S_RDY && !RST;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic capture_half(output logic [31:0] hw, output logic [31:0] lw, output int fn,
                              output logic [15:0] db, output int un, output int rn, output int bn);
    hw = '0; lw = '0; fn = 0; db = '0; un = 0; rn = 0; bn = 0;
    for (int p = 0; p < 16; p++) begin
      if (p % 2 == 0)
        for (int c = 0; c < 4; c++) begin
          hw[8*c +: 8] = {hw[8*c +: 7], lh[c]};
          lw[8*c +: 8] = {lw[8*c +: 7], ll[c]};
        end
      fn += int'(FCO); db[p] = DCO; un += int'(UNDERRUN); rn += int'(S_RDY); bn += int'(BUSY);
      tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0;
    tick(); tick();
    checks++; if (outs !== 12'h0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", outs, 12'h0); end
    checks++; if (S_RDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", S_RDY); end
    RST = 1'b0;
    tick();
    checks++; if ({S_RDY, BUSY} !== 2'b10) begin errors++; $display("FAIL reset_release: rdy/busy got %b expected 10", {S_RDY, BUSY}); end
  endtask

  task automatic test_preamble_underrun();
    logic [31:0] hw, lw; logic [15:0] db; int fn, un, rn, bn;
    EN = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      capture_half(hw, lw, fn, db, un, rn, bn);
      checks++; if ({hw, lw} !== {32'h80808080, 32'h0}) begin errors++; $display("FAIL pre_data[%0d]: got %h expected %h", k, {hw, lw}, {32'h80808080, 32'h0}); end
      checks++; if (fn !== (k % 2 == 0 ? 16 : 0)) begin errors++; $display("FAIL pre_fco[%0d]: got %0d expected %0d", k, fn, (k % 2 == 0 ? 16 : 0)); end
      checks++; if (db !== 16'h6666) begin errors++; $display("FAIL pre_dco[%0d]: got %h expected 6666", k, db); end
      checks++; if (un !== (k >= 4 ? 1 : 0)) begin errors++; $display("FAIL pre_underrun[%0d]: got %0d expected %0d", k, un, (k >= 4 ? 1 : 0)); end
      checks++; if (bn !== 16) begin errors++; $display("FAIL pre_busy[%0d]: got %0d expected 16", k, bn); end
    end
  endtask

  task automatic test_single_sample();
    logic [31:0] hw, lw; logic [15:0] db; int fn, un, rn, bn;
    q.push_back({14'h2AAA, 14'h0000, 14'h3FFF, 14'h1234});
    capture_half(hw, lw, fn, db, un, rn, bn);
    checks++; if ({hw, un} !== {32'h80808080, 32'd1}) begin errors++; $display("FAIL single_prev_half: got %h/%0d expected 80808080/1", hw, un); end
    capture_half(hw, lw, fn, db, un, rn, bn);
    checks++; if (hw !== 32'hAA00FF48) begin errors++; $display("FAIL single_h: got %h expected AA00FF48", hw); end
    checks++; if (lw !== 32'hA800FCD0) begin errors++; $display("FAIL single_l: got %h expected A800FCD0", lw); end
    checks++; if ({fn, un} !== {32'd0, 32'd0}) begin errors++; $display("FAIL single_fco_und: got %0d/%0d expected 0/0", fn, un); end
    checks++; if (db !== 16'h6666) begin errors++; $display("FAIL single_dco: got %h expected 6666", db); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hw, lw, eh, el; logic [15:0] db; int fn, un, rn, bn;
    logic [55:0] smp [8];
    for (int k = 0; k < 8; k++) begin
      smp[k] = {14'(k * 555 + 3), 14'(k * 2048 + 5), 14'(16383 - k * 97), 14'(3000 * k + 1)};
      q.push_back(smp[k]);
    end
    capture_half(hw, lw, fn, db, un, rn, bn);
    for (int k = 0; k < 8; k++) begin
      capture_half(hw, lw, fn, db, un, rn, bn);
      for (int c = 0; c < 4; c++) begin
        eh[8*c +: 8] = smp[k][14*c + 6 +: 8];
        el[8*c +: 8] = {smp[k][14*c +: 6], 2'b00};
      end
      checks++; if ({hw, lw} !== {eh, el}) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, {hw, lw}, {eh, el}); end
      checks++; if (fn !== (k % 2 == 1 ? 16 : 0)) begin errors++; $display("FAIL b2b_fco[%0d]: got %0d expected %0d", k, fn, (k % 2 == 1 ? 16 : 0)); end
      checks++; if (un !== 0) begin errors++; $display("FAIL b2b_underrun[%0d]: got %0d expected 0", k, un); end
      if (k < 7) begin
        checks++; if (rn !== 1) begin errors++; $display("FAIL b2b_rdy[%0d]: got %0d expected 1", k, rn); end
      end
    end
  endtask

  task automatic test_stop_mid_frame();
    logic [31:0] hw, lw; logic [15:0] db; int fn, un, rn, bn, bc, fc;
    capture_half(hw, lw, fn, db, un, rn, bn);
    repeat (4) tick();
    EN = 1'b0;
    bc = 0; fc = 0;
    for (int i = 0; i < 28; i++) begin
      bc += int'(BUSY); fc += int'(FCO);
      tick();
    end
    checks++; if (bc !== 28) begin errors++; $display("FAIL stop_busy: got %0d expected 28", bc); end
    checks++; if (fc !== 12) begin errors++; $display("FAIL stop_fco: got %0d expected 12", fc); end
    checks++; if (outs !== 12'h0) begin errors++; $display("FAIL stop_idle: got %h expected %h", outs, 12'h0); end
  endtask

  task automatic test_preload();
    logic [31:0] hw, lw; logic [15:0] db; int fn, un, rn, bn;
    q.push_back({14'h2AAA, 14'h1555, 14'h003F, 14'h3FC0});
    tick();
    checks++; if ({S_RDY, BUSY} !== 2'b00) begin errors++; $display("FAIL preload_rdy: got %b expected 00", {S_RDY, BUSY}); end
    EN = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      capture_half(hw, lw, fn, db, un, rn, bn);
      checks++; if ({hw, lw} !== {32'h80808080, 32'h0}) begin errors++; $display("FAIL preload_pre[%0d]: got %h expected %h", k, {hw, lw}, {32'h80808080, 32'h0}); end
      if (k == 0) begin
        checks++; if ({fn, rn} !== {32'd16, 32'd0}) begin errors++; $display("FAIL preload_first: fco/rdy got %0d/%0d expected 16/0", fn, rn); end
      end
    end
    capture_half(hw, lw, fn, db, un, rn, bn);
    checks++; if ({hw, lw} !== {32'hAA5500FF, 32'hA854FC00}) begin errors++; $display("FAIL preload_data: got %h expected %h", {hw, lw}, {32'hAA5500FF, 32'hA854FC00}); end
    checks++; if ({fn, un} !== {32'd16, 32'd0}) begin errors++; $display("FAIL preload_fco_und: got %0d/%0d expected 16/0", fn, un); end
    EN = 1'b0;
    capture_half(hw, lw, fn, db, un, rn, bn);
    checks++; if ({fn, un} !== {32'd0, 32'd1}) begin errors++; $display("FAIL preload_tail: got %0d/%0d expected 0/1", fn, un); end
    checks++; if (outs !== 12'h0) begin errors++; $display("FAIL preload_idle: got %h expected %h", outs, 12'h0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] hw, lw; logic [15:0] db; int fn, un, rn, bn;
    q.push_back({14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF});
    tick();
    checks++; if (S_RDY !== 1'b0) begin errors++; $display("FAIL rst_hold_full: got %b expected 0", S_RDY); end
    EN = 1'b1;
    tick();
    repeat (9) tick();
    checks++; if ({BUSY, DCO} !== 2'b11) begin errors++; $display("FAIL rst_ph9: busy/dco got %b expected 11", {BUSY, DCO}); end
    RST = 1'b1; EN = 1'b0;
    tick();
    checks++; if ({outs, S_RDY} !== 13'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected %h", {outs, S_RDY}, 13'h0); end
    RST = 1'b0;
    tick();
    checks++; if (S_RDY !== 1'b1) begin errors++; $display("FAIL rst_mid_lost: rdy got %b expected 1", S_RDY); end
    EN = 1'b1;
    tick();
    repeat (4) capture_half(hw, lw, fn, db, un, rn, bn);
    capture_half(hw, lw, fn, db, un, rn, bn);
    checks++; if ({hw, un} !== {32'h80808080, 32'd1}) begin errors++; $display("FAIL rst_mid_first_run: got %h/%0d expected 80808080/1", hw, un); end
    EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preamble_underrun();
    test_single_sample();
    test_back_to_back();
    test_stop_mid_frame();
    test_preload();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
